// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv_alu_pkg
// Description : Shared constants for the ALU issue front end: ALU control
//               codes, RV32I opcode/funct3 values and the issue FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_alu_pkg;

    // ALU control words. PASS is not decoded by the ALU; it falls into the
    // ALU default arm, which returns operand A.
    localparam logic [3:0] c_ALU_AND  = 4'b0000;
    localparam logic [3:0] c_ALU_OR   = 4'b0001;
    localparam logic [3:0] c_ALU_ADD  = 4'b0010;
    localparam logic [3:0] c_ALU_SUB  = 4'b0110;
    localparam logic [3:0] c_ALU_PASS = 4'b1111;

    // RV32I major opcodes handled by this block
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] c_F3_ADD = 3'b000;
    localparam logic [2:0] c_F3_OR  = 3'b110;
    localparam logic [2:0] c_F3_AND = 3'b111;
    localparam logic [2:0] c_F3_BEQ = 3'b000;
    localparam logic [2:0] c_F3_BNE = 3'b001;

    // Issue FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu_issue_if
// Description : Bundles the instruction-in handshake, the ALU operand/result
//               path and the response-out handshake of alu_issue_ctrl.
//               slave  : view taken by alu_issue_ctrl
//               master : view taken by the surrounding pipeline / ALU
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_if #(
    parameter int XLEN = 32
);
    // instruction record handshake
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    // ALU path
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    // response handshake
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] wb_data;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            illegal;

    modport slave (
        input  in_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm, pc,
               alu_result, alu_zero, out_ready,
        output in_ready, alu_a, alu_b, alu_ctrl, out_valid, wb_data,
               br_taken, br_target, illegal
    );

    modport master (
        output in_valid, opcode, funct3, funct7_5, rs1_val, rs2_val, imm, pc,
               alu_result, alu_zero, out_ready,
        input  in_ready, alu_a, alu_b, alu_ctrl, out_valid, wb_data,
               br_taken, br_target, illegal
    );

endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_dec
// Description : Combinational RV32I -> ALU control decoder.
//               in  : opcode[6:0], funct3[2:0], funct7_5
//               out : alu_ctrl[3:0], use_imm, is_branch, br_ne, illegal
//               Unsupported encodings decode to PASS with illegal set.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
    import rv_alu_pkg::*;
(
    input  wire logic [6:0] opcode,
    input  wire logic [2:0] funct3,
    input  wire logic       funct7_5,
    output logic      [3:0] alu_ctrl,
    output logic            use_imm,
    output logic            is_branch,
    output logic            br_ne,
    output logic            illegal
);

    always_comb begin
        alu_ctrl  = c_ALU_PASS;
        use_imm   = 1'b0;
        is_branch = 1'b0;
        br_ne     = 1'b0;
        illegal   = 1'b1;

        case (opcode)
            c_OP_RTYPE: begin
                case (funct3)
                    c_F3_ADD: begin
                        alu_ctrl = funct7_5 ? c_ALU_SUB : c_ALU_ADD;
                        illegal  = 1'b0;
                    end
                    c_F3_AND: begin alu_ctrl = c_ALU_AND; illegal = 1'b0; end
                    c_F3_OR:  begin alu_ctrl = c_ALU_OR;  illegal = 1'b0; end
                    default:  ;
                endcase
            end
            c_OP_ITYPE: begin
                use_imm = 1'b1;
                case (funct3)
                    c_F3_ADD: begin alu_ctrl = c_ALU_ADD; illegal = 1'b0; end
                    c_F3_AND: begin alu_ctrl = c_ALU_AND; illegal = 1'b0; end
                    c_F3_OR:  begin alu_ctrl = c_ALU_OR;  illegal = 1'b0; end
                    default:  ;
                endcase
            end
            // effective address = rs1 + imm, regardless of access width
            c_OP_LOAD, c_OP_STORE: begin
                alu_ctrl = c_ALU_ADD;
                use_imm  = 1'b1;
                illegal  = 1'b0;
            end
            c_OP_BRANCH: begin
                if (funct3 == c_F3_BEQ || funct3 == c_F3_BNE) begin
                    alu_ctrl  = c_ALU_SUB;
                    is_branch = 1'b1;
                    br_ne     = (funct3 == c_F3_BNE);
                    illegal   = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Sequencing front end for the integer ALU. Accepts a decoded
//               instruction, drives registered operands into the external
//               combinational ALU for one cycle, and returns a write-back /
//               branch-resolution record.
//               clk   : rising-edge clock
//               rst_n : synchronous active-low reset
//               bus   : alu_issue_if.slave (in handshake, ALU path, response)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    alu_issue_if.slave bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_in_ready;
    logic            w_accept;

    logic [3:0]      w_dec_ctrl;
    logic            w_dec_use_imm;
    logic            w_dec_is_branch;
    logic            w_dec_br_ne;
    logic            w_dec_illegal;

    // operand stage (valid from EXEC onward)
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [3:0]      r_alu_ctrl;
    logic            r_is_branch;
    logic            r_br_ne;
    logic            r_illegal_op;
    logic [XLEN-1:0] r_target_op;

    // response stage (valid in RESP)
    logic [XLEN-1:0] r_wb_data;
    logic            r_br_taken;
    logic [XLEN-1:0] r_br_target;
    logic            r_illegal;

    logic [XLEN-1:0] w_wb_data;
    logic            w_br_taken;

    alu_ctrl_dec u_dec (
        .opcode    (bus.opcode),
        .funct3    (bus.funct3),
        .funct7_5  (bus.funct7_5),
        .alu_ctrl  (w_dec_ctrl),
        .use_imm   (w_dec_use_imm),
        .is_branch (w_dec_is_branch),
        .br_ne     (w_dec_br_ne),
        .illegal   (w_dec_illegal)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = S_EXEC;
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                // retiring the response frees the operand stage this edge
                w_in_ready = bus.out_ready;
                if (bus.out_ready) w_state_nxt = bus.in_valid ? S_EXEC : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // ready is withheld for the whole time reset is asserted
        w_in_ready = w_in_ready & rst_n;
    end

    assign w_accept = w_in_ready & bus.in_valid;

    // ------------------------------------------------- response formation
    // The ALU leaves its result untouched on a zero SUB, so that case is
    // forced to 0 here rather than trusting alu_result.
    always_comb begin
        if (r_illegal_op)
            w_wb_data = r_alu_a;
        else if (r_alu_ctrl == c_ALU_SUB && bus.alu_zero)
            w_wb_data = '0;
        else
            w_wb_data = bus.alu_result;
    end

    assign w_br_taken = r_is_branch & (r_br_ne ? ~bus.alu_zero : bus.alu_zero);

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= 4'b0000;
            r_is_branch  <= 1'b0;
            r_br_ne      <= 1'b0;
            r_illegal_op <= 1'b0;
            r_target_op  <= '0;
            r_wb_data    <= '0;
            r_br_taken   <= 1'b0;
            r_br_target  <= '0;
            r_illegal    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a      <= bus.rs1_val;
                r_alu_b      <= w_dec_use_imm ? bus.imm : bus.rs2_val;
                r_alu_ctrl   <= w_dec_ctrl;
                r_is_branch  <= w_dec_is_branch;
                r_br_ne      <= w_dec_br_ne;
                r_illegal_op <= w_dec_illegal;
                r_target_op  <= bus.pc + bus.imm;
            end
            if (r_state == S_EXEC) begin
                r_wb_data   <= w_wb_data;
                r_br_taken  <= w_br_taken;
                r_br_target <= r_target_op;
                r_illegal   <= r_illegal_op;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_RESP);
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_ctrl  = r_alu_ctrl;
    assign bus.wb_data   = r_wb_data;
    assign bus.br_taken  = r_br_taken;
    assign bus.br_target = r_br_target;
    assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing front end for the integer ALU. Accepts one decoded instruction per valid/ready handshake, encodes the 4-bit ALU control word, drives registered operands into the combinational ALU, captures `ALU_result`/`Zero` and returns a write-back or branch-resolution record on a second valid/ready handshake. Sits between decode and write-back/PC-select; the ALU itself is unchanged.

## Interface
Parameters:
- `XLEN`, 32, datapath width (only 32 is supported).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  instruction record valid.
- `in_ready`  out  1  block can accept a record.
- `opcode`  in  7  RV32I opcode field.
- `funct3`  in  3  funct3 field.
- `funct7_5`  in  1  instruction bit 30.
- `rs1_val`, `rs2_val`  in  32  register operands.
- `imm`  in  32  sign-extended immediate.
- `pc`  in  32  instruction address.
- `alu_a`, `alu_b`  out  32  ALU operands (registered).
- `alu_ctrl`  out  4  ALU control word (registered).
- `alu_result`  in  32  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `out_valid`  out  1  response valid.
- `out_ready`  in  1  consumer accepts response.
- `wb_data`  out  32  result or memory address.
- `br_taken`  out  1  branch taken.
- `br_target`  out  32  `pc + imm`, modulo 2^32.
- `illegal`  out  1  unsupported encoding.

## Operation
- ALU control codes: AND=0000, OR=0001, ADD=0010, SUB=0110, PASS=1111. PASS falls through to the ALU default, which returns `A`.
- Decode by opcode:
  - 0110011 (R-type): funct3 000 gives ADD when `funct7_5`=0 and SUB when 1; 111 gives AND; 110 gives OR. `B` is `rs2_val`.
  - 0010011 (I-type): funct3 000 gives ADD, 111 AND, 110 OR. `B` is `imm`.
  - 0000011 and 0100011 (load/store): ADD with `B` = `imm`. The result is the effective address.
  - 1100011 (branch): funct3 000 (BEQ) and 001 (BNE) give SUB with `B` = `rs2_val`.
    - BEQ: `br_taken` = `alu_zero`. BNE: `br_taken` = !`alu_zero`.
  - Any other opcode/funct combination: PASS, `illegal`=1, `wb_data`=`rs1_val`.
- `alu_a` is always `rs1_val`.
- SUB rule: when `alu_zero`=1 the ALU does not update `ALU_result`, so `wb_data` is forced to 0. Otherwise `wb_data` = `alu_result`.
- `br_taken`=0 for every non-branch instruction.
- `br_target` comes from a local adder, not the ALU. It is computed for every record.
- State machine:
  - IDLE: `in_ready`=1. On accept, register the fields, drive `alu_a`/`alu_b`/`alu_ctrl`, and go to EXEC.
  - EXEC: `in_ready`=0. Capture ALU outputs into the response registers and go to RESP.
  - RESP: `out_valid`=1 and `in_ready`=`out_ready`.
    - `out_ready`=1 with `in_valid`=1: retire the response and accept the next record in the same cycle, then go to EXEC.
    - `out_ready`=1 with `in_valid`=0: go to IDLE.
    - `out_ready`=0: hold every output stable.

## Timing
- Accept at edge N. EXEC occupies cycle N+1. `out_valid` is high from cycle N+2.
- Maximum throughput is one record per 2 cycles.
- `alu_a`/`alu_b`/`alu_ctrl` hold their last values outside EXEC.
- The ALU path is combinational within the EXEC cycle: operand register to ALU to response register.
- Reset (`rst_n`=0 at an edge):
  - State returns to IDLE.
  - All outputs go to 0, including `alu_ctrl`=0000, `out_valid`=0 and `illegal`=0.
  - `in_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
  - Reset in EXEC or RESP discards the in-flight record. No response is produced.
- The handshake on each side completes only on an edge where valid and ready are both 1. `in_valid` asserted during EXEC is not accepted.

## Structure
- Shared package `rv_alu_pkg` holds:
  - ALU control localparams: AND, OR, ADD, SUB, PASS.
  - RV32I opcode constants.
  - State encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Sub-module `alu_ctrl_dec` is purely combinational.
  - Inputs: `opcode`, `funct3`, `funct7_5`.
  - Outputs: `alu_ctrl`, `use_imm`, `is_branch`, `br_ne`, `illegal`.
  - It is also reusable by the single-cycle datapath.
- The top level holds the FSM, operand/response registers and the target adder.

## Test plan
- R-type ADD, `rs1`=5, `rs2`=7: `alu_ctrl`=0010 in EXEC, `wb_data`=12, `out_valid` 2 cycles after accept, `br_taken`=0.
- R-type SUB (`funct7_5`=1), `rs1`=9, `rs2`=9: `alu_zero`=1 and `wb_data`=0. Then `rs1`=9, `rs2`=4: `wb_data`=5.
- BEQ, `rs1`=`rs2`=3, `pc`=0x100, `imm`=0x20: `br_taken`=1, `br_target`=0x120. BNE with the same operands: `br_taken`=0.
- ORI, `rs1`=0xF0, `imm`=0x0F: `alu_b`=0x0F, `alu_ctrl`=0001, `wb_data`=0xFF. Then opcode 0110111: `alu_ctrl`=1111, `illegal`=1, `wb_data`=`rs1`.
- Back-pressure:
  - `out_ready` low for 4 cycles: outputs stable and `in_ready`=0.
  - `out_ready` and `in_valid` raised together: retire plus accept in one edge, next `out_valid` 2 cycles later.
- `rst_n` low during EXEC: next cycle `out_valid`=0 and all outputs 0, no response emitted. `in_ready`=1 in the first cycle after release.
